// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully-connected layer engine acting as an Avalon-MM master on a 16-bit
// SDRAM bridge. For every output node it streams packed signed weight words and binary-pixel
// image words, sums the weights whose pixel bit is set, and writes one saturated 16-bit result.
// Build option: define FC_RELU_EN to write negative node results as zero.
module fc_layer_engine #(
    parameter int unsigned N_IN     = 784,
    parameter int unsigned N_OUT    = 200,
    parameter int unsigned W_BITS   = 4,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned IMG_BASE = 300000,
    parameter int unsigned W_BASE   = 800,
    parameter int unsigned OUT_BASE = 400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        chipselect,
    output logic [1:0]  byteenable,
    output logic        read_n,
    output logic        write_n,
    output logic [15:0] writedata,
    output logic [31:0] address,
    input  logic        ready,
    output logic        done,
    output logic        busy,
    output logic [31:0] toHexLed
);

    localparam int unsigned LANES = 16 / W_BITS;
    localparam int unsigned WORDS = N_IN / LANES;

    localparam logic signed [ACC_W-1:0] SatHi = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SatLo = ~SatHi;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StRdW  = 4'd1,
        StWtW  = 4'd2,
        StRdX  = 4'd3,
        StWtX  = 4'd4,
        StMac  = 4'd5,
        StWr   = 4'd6,
        StNext = 4'd7,
        StDone = 4'd8
    } state_e;

    state_e                   state_q;
    logic                     read_n_q, write_n_q, done_q, busy_q;
    logic [31:0]              address_q;
    logic [15:0]              writedata_q;
    logic [11:0]              node_cnt_q, word_cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [31:0]              w_ptr_q, x_ptr_q;
    logic [15:0]              w_word_q;
    logic [LANES-1:0]         pix_q;

    logic [LANES-1:0]         pix_bits;
    logic signed [W_BITS-1:0] lane_w;
    logic signed [ACC_W-1:0]  mac_sum, acc_sum;
    logic [15:0]              result;
    logic                     word_last, node_more;
    logic [31:0]              out_addr;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SatHi) begin
            return 16'h7fff;
        end else if (v < SatLo) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    // Only the low bit of each lane in an image word carries a pixel.
    always_comb begin
        pix_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            pix_bits[i] = readdata[i*W_BITS];
        end
    end

    // Masked sum of sign-extended weight lanes, and the accumulator after this word.
    always_comb begin
        mac_sum = '0;
        lane_w  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_w = w_word_q[i*W_BITS +: W_BITS];
            if (pix_q[i]) begin
                mac_sum = mac_sum + ACC_W'(lane_w);
            end
        end
        acc_sum = acc_q + mac_sum;
    end

    // Node result as it will be written; computed from the post-MAC accumulator.
    always_comb begin
`ifdef FC_RELU_EN
        result = acc_sum[ACC_W-1] ? 16'h0000 : sat16(acc_sum);
`else
        result = sat16(acc_sum);
`endif
    end

    // Loop-exit decisions and the result address of the current node.
    always_comb begin
        word_last = (32'(word_cnt_q) + 32'd1) >= WORDS;
        node_more = 32'(node_cnt_q) < N_OUT;
        out_addr  = 32'(OUT_BASE) + {19'd0, node_cnt_q, 1'b0};
    end

    // Control FSM; all bus outputs are registered and held while the slave stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            node_cnt_q  <= '0;
            word_cnt_q  <= '0;
            acc_q       <= '0;
            w_ptr_q     <= 32'(W_BASE);
            x_ptr_q     <= 32'(IMG_BASE);
            w_word_q    <= '0;
            pix_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    node_cnt_q <= '0;
                    word_cnt_q <= '0;
                    acc_q      <= '0;
                    w_ptr_q    <= 32'(W_BASE);
                    x_ptr_q    <= 32'(IMG_BASE);
                    if (ready) begin
                        busy_q    <= 1'b1;
                        read_n_q  <= 1'b0;
                        address_q <= 32'(W_BASE);
                        state_q   <= StRdW;
                    end
                end
                StRdW: begin
                    if (!waitrequest) begin
                        read_n_q <= 1'b1;
                        state_q  <= StWtW;
                    end
                end
                StWtW: begin
                    if (readdatavalid) begin
                        w_word_q  <= readdata;
                        w_ptr_q   <= w_ptr_q + 32'd2;
                        read_n_q  <= 1'b0;
                        address_q <= x_ptr_q;
                        state_q   <= StRdX;
                    end
                end
                StRdX: begin
                    if (!waitrequest) begin
                        read_n_q <= 1'b1;
                        state_q  <= StWtX;
                    end
                end
                StWtX: begin
                    if (readdatavalid) begin
                        pix_q   <= pix_bits;
                        x_ptr_q <= x_ptr_q + 32'd2;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q      <= acc_sum;
                    word_cnt_q <= word_cnt_q + 12'd1;
                    if (!word_last) begin
                        read_n_q  <= 1'b0;
                        address_q <= w_ptr_q;
                        state_q   <= StRdW;
                    end else begin
                        write_n_q   <= 1'b0;
                        address_q   <= out_addr;
                        writedata_q <= result;
                        state_q     <= StWr;
                    end
                end
                StWr: begin
                    if (!waitrequest) begin
                        write_n_q  <= 1'b1;
                        node_cnt_q <= node_cnt_q + 12'd1;
                        state_q    <= StNext;
                    end
                end
                StNext: begin
                    // Weight pointer keeps running: node weights are stored back to back.
                    acc_q      <= '0;
                    word_cnt_q <= '0;
                    x_ptr_q    <= 32'(IMG_BASE);
                    if (node_more) begin
                        read_n_q  <= 1'b0;
                        address_q <= w_ptr_q;
                        state_q   <= StRdW;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!ready) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign chipselect = 1'b1;
    assign byteenable = 2'b11;
    assign read_n     = read_n_q;
    assign write_n    = write_n_q;
    assign writedata  = writedata_q;
    assign address    = address_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign toHexLed   = {4'h0, node_cnt_q, word_cnt_q, state_q};

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: two engine instances (4-bit lanes N_IN=8, 16-bit lanes N_IN=4) behind a
// behavioural SDRAM slave with configurable stalls; bus traffic is scored against queues filled
// from an integer reference model of the layer.
`timescale 1ns/1ps
module tb_fc_layer_engine;

    localparam int unsigned IMG    = 300000;
    localparam int unsigned WB     = 800;
    localparam int unsigned OB     = 400000;
    localparam int          NOUT   = 2;
    localparam int          ST_MAC = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready_s [2];
    logic        wait_s  [2];
    logic        rdv_s   [2];
    logic [15:0] rdata_s [2];
    logic        cs_s    [2];
    logic [1:0]  be_s    [2];
    logic        rn_s    [2];
    logic        wn_s    [2];
    logic [15:0] wd_s    [2];
    logic [31:0] addr_s  [2];
    logic        done_s  [2];
    logic        busy_s  [2];
    logic [31:0] hex_s   [2];

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [longint];
    int unsigned exp_rd_q [$];
    int unsigned exp_wa_q [$];
    int unsigned exp_wd_q [$];

    int          stall_cfg = 0;
    int          stall_left [2];
    bit          pend       [2];
    int unsigned pend_addr  [2];
    bit          in_acc     [2];
    logic [31:0] hold_addr  [2];
    logic [15:0] hold_wd    [2];
    logic        hold_rn    [2];
    logic        hold_wn    [2];
    int          busy_cnt   [2];

    always #5 clk = ~clk;

    fc_layer_engine #(
        .N_IN(8), .N_OUT(NOUT), .W_BITS(4), .ACC_W(32),
        .IMG_BASE(IMG), .W_BASE(WB), .OUT_BASE(OB)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .waitrequest(wait_s[0]), .readdatavalid(rdv_s[0]),
        .readdata(rdata_s[0]), .chipselect(cs_s[0]), .byteenable(be_s[0]), .read_n(rn_s[0]),
        .write_n(wn_s[0]), .writedata(wd_s[0]), .address(addr_s[0]), .ready(ready_s[0]),
        .done(done_s[0]), .busy(busy_s[0]), .toHexLed(hex_s[0])
    );

    fc_layer_engine #(
        .N_IN(4), .N_OUT(NOUT), .W_BITS(16), .ACC_W(32),
        .IMG_BASE(IMG), .W_BASE(WB), .OUT_BASE(OB)
    ) u_dut16 (
        .clk(clk), .reset_n(reset_n), .waitrequest(wait_s[1]), .readdatavalid(rdv_s[1]),
        .readdata(rdata_s[1]), .chipselect(cs_s[1]), .byteenable(be_s[1]), .read_n(rn_s[1]),
        .write_n(wn_s[1]), .writedata(wd_s[1]), .address(addr_s[1]), .ready(ready_s[1]),
        .done(done_s[1]), .busy(busy_s[1]), .toHexLed(hex_s[1])
    );

    function automatic int words_of(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    function automatic int wbits_of(input int c);
        return (c == 0) ? 4 : 16;
    endfunction

    function automatic longint mkey(input int c, input int unsigned a);
        return (longint'(c) << 32) | longint'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event absent, required present", name);
    endtask

    // Layer reference: masked signed lane sum with plain integer arithmetic, then clamp.
    function automatic logic [15:0] model(input int c, input int n);
        int     wb, words, lanes, x, wt, f;
        longint acc;
        wb    = wbits_of(c);
        words = words_of(c);
        lanes = 16 / wb;
        acc   = 0;
        for (int w = 0; w < words; w++) begin
            x  = int'(mem[mkey(c, IMG + 2 * w)]);
            wt = int'(mem[mkey(c, WB + 2 * (n * words + w))]);
            for (int i = 0; i < lanes; i++) begin
                if (((x >> (i * wb)) & 1) == 1) begin
                    f = (wt >> (i * wb)) & ((1 << wb) - 1);
                    if (f >= (1 << (wb - 1))) f = f - (1 << wb);
                    acc += f;
                end
            end
        end
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 16'(acc);
    endfunction

    task automatic load_const(input int c, input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < NOUT * words_of(c); i++) mem[mkey(c, WB + 2 * i)] = w;
        for (int i = 0; i < words_of(c); i++) mem[mkey(c, IMG + 2 * i)] = x;
    endtask

    task automatic load_rand(input int c);
        for (int i = 0; i < NOUT * words_of(c); i++) mem[mkey(c, WB + 2 * i)] = 16'($urandom);
        for (int i = 0; i < words_of(c); i++) mem[mkey(c, IMG + 2 * i)] = 16'($urandom);
    endtask

    task automatic push_expect(input int c);
        for (int n = 0; n < NOUT; n++) begin
            for (int w = 0; w < words_of(c); w++) begin
                exp_rd_q.push_back(WB + 2 * (n * words_of(c) + w));
                exp_rd_q.push_back(IMG + 2 * w);
            end
            exp_wa_q.push_back(OB + 2 * n);
            exp_wd_q.push_back(32'(model(c, n)));
        end
    endtask

    task automatic clear_expect();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
    endtask

    // Slave model and monitor: inputs change on the falling edge, DUT samples on the rising one.
    task automatic slave_step(input int c);
        rdv_s[c] = 1'b0;
        if (!reset_n) begin
            pend[c] = 1'b0;
            in_acc[c] = 1'b0;
            wait_s[c] = 1'b0;
            return;
        end
        if (busy_s[c]) busy_cnt[c]++;
        if (pend[c]) begin
            rdv_s[c] = 1'b1;
            rdata_s[c] = mem.exists(mkey(c, pend_addr[c])) ? mem[mkey(c, pend_addr[c])] : 16'h0;
            pend[c] = 1'b0;
        end
        if (!rn_s[c] || !wn_s[c]) begin
            if (in_acc[c]) begin
                chk("stall_address_stable", addr_s[c], hold_addr[c]);
                chk("stall_read_n_stable", {31'd0, rn_s[c]}, {31'd0, hold_rn[c]});
                chk("stall_write_n_stable", {31'd0, wn_s[c]}, {31'd0, hold_wn[c]});
                if (!wn_s[c]) chk("stall_writedata_stable", {16'd0, wd_s[c]}, {16'd0, hold_wd[c]});
            end else begin
                in_acc[c] = 1'b1;
                hold_addr[c] = addr_s[c];
                hold_wd[c] = wd_s[c];
                hold_rn[c] = rn_s[c];
                hold_wn[c] = wn_s[c];
                stall_left[c] = stall_cfg;
            end
            if (stall_left[c] > 0) begin
                wait_s[c] = 1'b1;
                stall_left[c]--;
            end else begin
                wait_s[c] = 1'b0;
                in_acc[c] = 1'b0;
                chk("no_read_write_overlap", {31'd0, rn_s[c] | wn_s[c]}, 32'd1);
                if (!rn_s[c]) begin
                    pend[c] = 1'b1;
                    pend_addr[c] = addr_s[c];
                    if (exp_rd_q.size() == 0) flag("read_expected");
                    else chk("read_address", addr_s[c], exp_rd_q.pop_front());
                end else begin
                    if (exp_wa_q.size() == 0) begin
                        flag("write_expected");
                    end else begin
                        chk("write_address", addr_s[c], exp_wa_q.pop_front());
                        chk("write_data", {16'd0, wd_s[c]}, exp_wd_q.pop_front());
                    end
                end
            end
        end else begin
            wait_s[c] = 1'b0;
            in_acc[c] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        slave_step(0);
        slave_step(1);
    end

    task automatic check_reset_outputs(input int c);
        chk("reset_read_n", {31'd0, rn_s[c]}, 32'd1);
        chk("reset_write_n", {31'd0, wn_s[c]}, 32'd1);
        chk("reset_done", {31'd0, done_s[c]}, 32'd0);
        chk("reset_busy", {31'd0, busy_s[c]}, 32'd0);
        chk("reset_address", addr_s[c], 32'd0);
        chk("reset_writedata", {16'd0, wd_s[c]}, 32'd0);
        chk("reset_hexled", hex_s[c], 32'd0);
    endtask

    // Wait for DONE with a cycle budget, then confirm completion state and return to IDLE.
    task automatic finish_run(input int c, input bit chk_time);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_s[c]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            flag("done_within_budget");
            reset_n = 1'b0;
            ready_s[c] = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            clear_expect();
            return;
        end
        chk("done_busy_low", {31'd0, busy_s[c]}, 32'd0);
        chk("writes_all_seen", exp_wa_q.size(), 32'd0);
        chk("reads_all_seen", exp_rd_q.size(), 32'd0);
        if (chk_time) chk("busy_cycles", busy_cnt[c], NOUT * (5 * words_of(c) + 2));
        @(negedge clk);
        chk("done_clears_in_idle", {31'd0, done_s[c]}, 32'd0);
        clear_expect();
    endtask

    task automatic run(input int c, input int stall, input bit chk_time);
        push_expect(c);
        stall_cfg = stall;
        busy_cnt[c] = 0;
        ready_s[c] = 1'b1;
        @(negedge clk);
        ready_s[c] = 1'b0; // dropping ready mid-run must not stop the layer
        finish_run(c, chk_time);
    endtask

    initial begin
        bit found;
        for (int c = 0; c < 2; c++) begin
            ready_s[c] = 1'b0;
            wait_s[c] = 1'b0;
            rdv_s[c] = 1'b0;
            rdata_s[c] = 16'h0;
            stall_left[c] = 0;
            pend[c] = 1'b0;
            in_acc[c] = 1'b0;
            busy_cnt[c] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        chk("chipselect_tied", {31'd0, cs_s[0]}, 32'd1);
        chk("byteenable_tied", {30'd0, be_s[0]}, 32'd3);
        reset_n = 1'b1;
        @(negedge clk);

        // 4-bit lanes: directed patterns, zero-wait and stalled.
        load_const(0, 16'h1111, 16'h1111);
        run(0, 0, 1'b1);
        load_const(0, 16'hffff, 16'h1111);
        run(0, 0, 1'b1);
        load_const(0, 16'h7777, 16'h0101);
        run(0, 0, 1'b0);
        load_const(0, 16'h1111, 16'h1111);
        run(0, 3, 1'b0);
        load_const(0, 16'h7777, 16'h0101);
        run(0, 3, 1'b0);
        for (int t = 0; t < 6; t++) begin
            load_rand(0);
            run(0, int'($urandom_range(0, 3)), 1'b0);
        end

        // 16-bit lanes: positive and negative saturation, then random.
        load_const(1, 16'h7fff, 16'h0001);
        run(1, 0, 1'b1);
        load_const(1, 16'h8000, 16'h0001);
        run(1, 2, 1'b0);
        for (int t = 0; t < 4; t++) begin
            load_rand(1);
            run(1, int'($urandom_range(0, 3)), 1'b0);
        end

        // Asynchronous reset during node 1 accumulation, then a clean restart.
        load_rand(0);
        push_expect(0);
        stall_cfg = 0;
        ready_s[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hex_s[0][3:0] == 4'(ST_MAC) && hex_s[0][27:16] == 12'd1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) flag("reach_mac_node1");
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs(0);
        clear_expect();
        push_expect(0);
        busy_cnt[0] = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ready_s[0] = 1'b0;
        finish_run(0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
